register_file: RTL and testbench
================================

Name: register_file

Overview:
- 32-entry general-purpose register file for the TP4 MIPS pipeline.
- Receiving end of the write-back interface: it takes the write-back stage's write enable (from WB[1]) and the data already selected between memory data and ALU result.
- Provides two combinational read ports to the decode stage, with write-to-read bypass.
- Provides a handshaked sequential dump port so the debug unit can stream all registers out.

Parameters:
- DATA_W, 32, register and data width.
- ADDR_W, 5, register address width; NREG = 2**ADDR_W registers (localparam).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- inRegF_wr  input  1  write enable from the write-back stage.
- inRegF_wa  input  ADDR_W  destination register address.
- inRegF_wd  input  DATA_W  write data from the write-back stage.
- inRs_addr  input  ADDR_W  read port A address.
- inRt_addr  input  ADDR_W  read port B address.
- outRs_data  output  DATA_W  read port A data (combinational).
- outRt_data  output  DATA_W  read port B data (combinational).
- inDump_start  input  1  one-cycle request to begin a dump.
- outDump_valid  output  1  dump word valid.
- inDump_ready  input  1  debug unit accepts the dump word.
- outDump_idx  output  ADDR_W  index of the current dump word.
- outDump_data  output  DATA_W  current dump word.
- outDump_busy  output  1  dump in progress (SEND state).
- outDump_done  output  1  one-cycle pulse after the last word is accepted.

Behaviour:
- Reset (rst=0, asynchronous):
  - All registers are cleared to 0.
  - The FSM goes to IDLE, and outDump_idx is cleared to 0.
  - outDump_valid, outDump_busy and outDump_done are all 0.
  - Reset applied mid-dump aborts the dump immediately; no done pulse is produced.
- Write:
  - On the rising clk edge with inRegF_wr=1 and inRegF_wa!=0, regs[inRegF_wa] <= inRegF_wd.
  - Writes to address 0 are discarded; r0 always reads 0.
- Read (combinational, zero latency):
  - outX_data = 0 if addr==0.
  - Otherwise, inRegF_wd if inRegF_wr && inRegF_wa==addr (bypass, same cycle).
  - Otherwise, regs[addr].
  - Both ports are independent; the same address on both ports gives identical data.
- Dump FSM, states IDLE, SEND, DONE:
  - IDLE: outDump_valid=0. inDump_start=1 → idx<=0, go to SEND.
  - SEND: outDump_valid=1, outDump_busy=1, outDump_data = read of idx using the read-port rule (bypass included).
    - On valid&&ready with idx==NREG-1 → go to DONE.
    - On valid&&ready otherwise → idx<=idx+1.
    - Without ready, hold idx and valid; data may change only if the pipeline writes that index that cycle.
  - DONE: outDump_done=1 for exactly one cycle, then go to IDLE. idx holds NREG-1.
  - inDump_start is ignored in SEND and DONE.
  - A 32-word dump with ready held high takes 32 SEND cycles plus 1 DONE cycle.
- Pipeline writes continue normally during a dump; a dump is not a snapshot.
- No wrap-around past NREG-1; idx never increments from NREG-1.

Decomposition:
- Shared package (tp4_pkg): DATA_W and ADDR_W constants, dump FSM state encodings (IDLE=2'd0, SEND=2'd1, DONE=2'd2).
- Sub-module regfile_dump_ctrl: the FSM plus idx counter, with ports start/ready/valid/busy/done/idx. The storage array and read muxes remain in register_file.

Test Plan:
- Reset, then read every address on both ports → all 0; valid/busy/done all 0.
- Write 0xDEADBEEF to r5, next cycle read r5 on Rs and Rt → both return 0xDEADBEEF. Write 0x1234 to r0 → r0 reads 0.
- Bypass: in the same cycle, wr=1, wa=7, wd=0xA5A5A5A5, Rs=7 → outRs_data=0xA5A5A5A5 before the edge; regs[7] still holds its old value.
- Dump with ready=1, regs[i]=i*4 preloaded:
  - Pulse start → 32 accepted words, idx 0..31, data 0,4,...,124.
  - done high on exactly the cycle after idx 31 is accepted; busy then falls.
- Backpressure: ready toggles 1,0,0,1 during a dump → idx advances only on ready=1; valid stays high. A write to r3 while idx=3 is stalled → outDump_data shows the new value that cycle.
- Reset asserted while idx=10 → valid/busy drop immediately, no done pulse. A new start then dumps from idx 0.

Source files
------------

// File: rtl/tp4_pkg.sv
// Shared constants and dump FSM encodings for the TP4 register file.
package tp4_pkg;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      DONE = 2'd2
   } dump_state_e;

endpackage

// File: rtl/regfile_dump_ctrl.sv
// Dump sequencer: walks idx 0..NREG-1 under a valid/ready handshake, then pulses done.
module regfile_dump_ctrl
   import tp4_pkg::*;
#(
   parameter int ADDR_W_P = ADDR_W
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start_i,
   input  logic                ready_i,
   output logic                valid_o,
   output logic                busy_o,
   output logic                done_o,
   output logic [ADDR_W_P-1:0] idx_o,
   output dump_state_e         state_o
);

   // Handshake: a word transfers on any rising edge where valid_o && ready_i;
   // valid_o never drops while a word is pending, and idx_o holds until it transfers.
   dump_state_e         state_q;
   logic [ADDR_W_P-1:0] idx_q;
   logic                valid_q;
   logic                busy_q;
   logic                done_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               if (start_i) begin
                  state_q <= SEND;
                  idx_q   <= '0;
                  valid_q <= 1'b1;
                  busy_q  <= 1'b1;
               end
            end
            SEND: begin
               if (ready_i) begin
                  // The last index never increments, so idx stays at NREG-1 through DONE.
                  if (idx_q == '1) begin
                     state_q <= DONE;
                     valid_q <= 1'b0;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end else begin
                     idx_q <= idx_q + 1'b1;
                  end
               end
            end
            DONE: begin
               state_q <= IDLE;
               done_q  <= 1'b0;
            end
            default: begin
               state_q <= IDLE;
               valid_q <= 1'b0;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign valid_o = valid_q;
   assign busy_o  = busy_q;
   assign done_o  = done_q;
   assign idx_o   = idx_q;
   assign state_o = state_q;

endmodule

// File: rtl/register_file.sv
// 32-entry MIPS register file: write-back port, two bypassed read ports, debug dump port.
module register_file
   import tp4_pkg::*;
#(
   parameter int DATA_W_P = DATA_W,
   parameter int ADDR_W_P = ADDR_W
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                inRegF_wr,
   input  logic [ADDR_W_P-1:0] inRegF_wa,
   input  logic [DATA_W_P-1:0] inRegF_wd,
   input  logic [ADDR_W_P-1:0] inRs_addr,
   input  logic [ADDR_W_P-1:0] inRt_addr,
   output logic [DATA_W_P-1:0] outRs_data,
   output logic [DATA_W_P-1:0] outRt_data,
   input  logic                inDump_start,
   output logic                outDump_valid,
   input  logic                inDump_ready,
   output logic [ADDR_W_P-1:0] outDump_idx,
   output logic [DATA_W_P-1:0] outDump_data,
   output logic                outDump_busy,
   output logic                outDump_done
);

   localparam int NREG = 2 ** ADDR_W_P;

   logic [DATA_W_P-1:0] regs_q [NREG];
   dump_state_e         dump_state;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NREG; i++) begin
            regs_q[i] <= '0;
         end
      end else if (inRegF_wr && (inRegF_wa != '0)) begin
         regs_q[inRegF_wa] <= inRegF_wd;
      end
   end

   // r0 is hardwired to zero; otherwise a same-cycle write wins over stored data.
   function automatic logic [DATA_W_P-1:0] read_port(input logic [ADDR_W_P-1:0] addr);
      logic [DATA_W_P-1:0] data;
      data = '0;
      if (addr == '0) begin
         data = '0;
      end else if (inRegF_wr && (inRegF_wa == addr)) begin
         data = inRegF_wd;
      end else begin
         data = regs_q[addr];
      end
      return data;
   endfunction

   always_comb begin
      outRs_data   = read_port(inRs_addr);
      outRt_data   = read_port(inRt_addr);
      outDump_data = '0;
      if (dump_state == SEND) begin
         outDump_data = read_port(outDump_idx);
      end
   end

   regfile_dump_ctrl #(
      .ADDR_W_P (ADDR_W_P)
   ) u_dump_ctrl (
      .clk     (clk),
      .rst_n   (rst),
      .start_i (inDump_start),
      .ready_i (inDump_ready),
      .valid_o (outDump_valid),
      .busy_o  (outDump_busy),
      .done_o  (outDump_done),
      .idx_o   (outDump_idx),
      .state_o (dump_state)
   );

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: reset, write/read, bypass, dump, backpressure, reset abort.
module tb_register_file;

   logic        clk;
   logic        rst;
   logic        inRegF_wr;
   logic [4:0]  inRegF_wa;
   logic [31:0] inRegF_wd;
   logic [4:0]  inRs_addr;
   logic [4:0]  inRt_addr;
   logic [31:0] outRs_data;
   logic [31:0] outRt_data;
   logic        inDump_start;
   logic        outDump_valid;
   logic        inDump_ready;
   logic [4:0]  outDump_idx;
   logic [31:0] outDump_data;
   logic        outDump_busy;
   logic        outDump_done;

   int n_checks;
   int n_pass;
   logic [31:0] exp_q [$];

   register_file dut (
      .clk           (clk),
      .rst           (rst),
      .inRegF_wr     (inRegF_wr),
      .inRegF_wa     (inRegF_wa),
      .inRegF_wd     (inRegF_wd),
      .inRs_addr     (inRs_addr),
      .inRt_addr     (inRt_addr),
      .outRs_data    (outRs_data),
      .outRt_data    (outRt_data),
      .inDump_start  (inDump_start),
      .outDump_valid (outDump_valid),
      .inDump_ready  (inDump_ready),
      .outDump_idx   (outDump_idx),
      .outDump_data  (outDump_data),
      .outDump_busy  (outDump_busy),
      .outDump_done  (outDump_done)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %h, want %h", tag, obs, exp);
      end
   endtask

   // Inputs change on the falling edge; checks run 1ns later.
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic write_reg(input logic [4:0] wa, input logic [31:0] wd);
      inRegF_wr = 1'b1;
      inRegF_wa = wa;
      inRegF_wd = wd;
      step();
      inRegF_wr = 1'b0;
   endtask

   task automatic check_dump_flags(input string tag, input logic v, input logic b, input logic d);
      check({tag, "_valid"}, {31'd0, outDump_valid}, {31'd0, v});
      check({tag, "_busy"},  {31'd0, outDump_busy},  {31'd0, b});
      check({tag, "_done"},  {31'd0, outDump_done},  {31'd0, d});
   endtask

   initial begin
      n_checks     = 0;
      n_pass       = 0;
      rst          = 1'b0;
      inRegF_wr    = 1'b0;
      inRegF_wa    = '0;
      inRegF_wd    = '0;
      inRs_addr    = '0;
      inRt_addr    = '0;
      inDump_start = 1'b0;
      inDump_ready = 1'b0;
      repeat (3) step();
      rst = 1'b1;
      step();

      // reset state
      for (int a = 0; a < 32; a++) begin
         inRs_addr = 5'(a);
         inRt_addr = 5'(31 - a);
         #1;
         check("rst_rs", outRs_data, 32'd0);
         check("rst_rt", outRt_data, 32'd0);
      end
      check_dump_flags("rst", 1'b0, 1'b0, 1'b0);
      check("rst_idx", {27'd0, outDump_idx}, 32'd0);

      // write / read, r0 discard
      write_reg(5'd5, 32'hDEADBEEF);
      inRs_addr = 5'd5;
      inRt_addr = 5'd5;
      #1;
      check("r5_rs", outRs_data, 32'hDEADBEEF);
      check("r5_rt", outRt_data, 32'hDEADBEEF);
      inRegF_wr = 1'b1;
      inRegF_wa = 5'd0;
      inRegF_wd = 32'h1234;
      inRs_addr = 5'd0;
      #1;
      check("r0_bypass", outRs_data, 32'd0);
      step();
      inRegF_wr = 1'b0;
      #1;
      check("r0_after", outRs_data, 32'd0);

      // bypass: old value of r7 survives until the edge
      write_reg(5'd7, 32'h11111111);
      inRegF_wr = 1'b1;
      inRegF_wa = 5'd7;
      inRegF_wd = 32'hA5A5A5A5;
      inRs_addr = 5'd7;
      inRt_addr = 5'd5;
      #1;
      check("byp_rs", outRs_data, 32'hA5A5A5A5);
      check("byp_rt_other", outRt_data, 32'hDEADBEEF);
      inRegF_wr = 1'b0;
      #1;
      check("byp_old", outRs_data, 32'h11111111);
      write_reg(5'd7, 32'hA5A5A5A5);
      #1;
      check("byp_written", outRs_data, 32'hA5A5A5A5);

      // preload regs[i] = i*4 and fill the scoreboard
      for (int i = 1; i < 32; i++) begin
         write_reg(5'(i), 32'(i * 4));
      end
      for (int i = 0; i < 32; i++) begin
         exp_q.push_back(32'(i * 4));
      end

      // full dump, ready held high
      inDump_ready = 1'b1;
      inDump_start = 1'b1;
      step();
      inDump_start = 1'b0;
      for (int k = 0; k < 32; k++) begin
         #1;
         check_dump_flags("dump", 1'b1, 1'b1, 1'b0);
         check("dump_idx", {27'd0, outDump_idx}, 32'(k));
         if (exp_q.size() > 0) begin
            check("dump_data", outDump_data, exp_q.pop_front());
         end
         step();
      end
      #1;
      check_dump_flags("dump_end", 1'b0, 1'b0, 1'b1);
      check("dump_end_idx", {27'd0, outDump_idx}, 32'd31);
      inDump_start = 1'b1;
      step();
      inDump_start = 1'b0;
      #1;
      check_dump_flags("dump_idle", 1'b0, 1'b0, 1'b0);
      check("dump_idle_idx", {27'd0, outDump_idx}, 32'd31);
      step();

      // backpressure: ready 1,0,0,1
      inDump_start = 1'b1;
      step();
      inDump_start = 1'b0;
      inDump_ready = 1'b1;
      #1;
      check("bp_idx0", {27'd0, outDump_idx}, 32'd0);
      step();
      inDump_ready = 1'b0;
      #1;
      check("bp_stall1_idx", {27'd0, outDump_idx}, 32'd1);
      check("bp_stall1_valid", {31'd0, outDump_valid}, 32'd1);
      step();
      #1;
      check("bp_stall2_idx", {27'd0, outDump_idx}, 32'd1);
      check("bp_stall2_valid", {31'd0, outDump_valid}, 32'd1);
      inDump_ready = 1'b1;
      #1;
      check("bp_release_data", outDump_data, 32'd4);
      step();
      #1;
      check("bp_idx2", {27'd0, outDump_idx}, 32'd2);
      check("bp_idx2_data", outDump_data, 32'd8);
      step();
      inDump_ready = 1'b0;
      inRegF_wr    = 1'b1;
      inRegF_wa    = 5'd3;
      inRegF_wd    = 32'hCAFEF00D;
      #1;
      check("bp_idx3", {27'd0, outDump_idx}, 32'd3);
      check("bp_wr_bypass", outDump_data, 32'hCAFEF00D);
      step();
      inRegF_wr = 1'b0;
      #1;
      check("bp_wr_stored", outDump_data, 32'hCAFEF00D);
      check("bp_idx3_hold", {27'd0, outDump_idx}, 32'd3);
      inDump_ready = 1'b1;
      for (int k = 3; k < 10; k++) begin
         step();
      end
      #1;
      check("abort_idx10", {27'd0, outDump_idx}, 32'd10);

      // asynchronous reset mid-dump
      rst = 1'b0;
      #1;
      check_dump_flags("abort", 1'b0, 1'b0, 1'b0);
      check("abort_idx", {27'd0, outDump_idx}, 32'd0);
      step();
      #1;
      check("abort_no_done", {31'd0, outDump_done}, 32'd0);
      rst = 1'b1;
      step();
      inRs_addr = 5'd3;
      #1;
      check("abort_regs_clear", outRs_data, 32'd0);

      // fresh dump starts from index 0
      inDump_start = 1'b1;
      step();
      inDump_start = 1'b0;
      #1;
      check("restart_idx0", {27'd0, outDump_idx}, 32'd0);
      check("restart_valid", {31'd0, outDump_valid}, 32'd1);
      step();
      #1;
      check("restart_idx1", {27'd0, outDump_idx}, 32'd1);
      check("restart_data1", outDump_data, 32'd0);

      // report
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
